// File: rtl/alu_sweep_controller.sv
// Clocked sweep engine: walks every {A,B,op} vector through a golden and a suspect ALU
// in lockstep, compares after a settle time, counts mismatches and captures the first.
module alu_sweep_controller #(
  parameter int DATA_W        = 4,
  parameter int OP_W          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      stop_on_first,
  output logic [DATA_W-1:0]         A,
  output logic [DATA_W-1:0]         B,
  output logic [OP_W-1:0]           op,
  input  logic [DATA_W-1:0]         clean_result,
  input  logic [DATA_W-1:0]         trojan_result,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_W+OP_W:0]    mismatch_count,
  output logic                      first_mismatch_valid,
  output logic [2*DATA_W+OP_W-1:0]  first_mismatch_vec,
  output logic                      trojan_flag
);

  localparam int VEC_W = 2*DATA_W + OP_W;
  localparam int CNT_W = VEC_W + 1;
  localparam logic [VEC_W-1:0] LAST_IDX = '1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   idx;
  logic [3:0]         settle_cnt;
  logic               sof_q;
  logic               load_sweep;
  logic               advance;
  logic               cmp_fire;
  logic               mism;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign mism     = (clean_result != trojan_result);
  assign cmp_fire = (state == COMPARE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_sweep = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = SETTLE;
          load_sweep = 1'b1;
        end
      end
      SETTLE: begin
        if (abort)                state_nxt = IDLE;
        else if (settle_cnt == '0) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if ((idx == LAST_IDX) || (sof_q && mism)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SETTLE;
          advance   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle timer reloads on every entry into SETTLE and counts down to zero.
  always_ff @(posedge clk) begin
    if (rst)                        settle_cnt <= '0;
    else if (load_sweep || advance) settle_cnt <= SETTLE_LOAD;
    else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx                  <= '0;
      sof_q                <= 1'b0;
      mismatch_count       <= '0;
      first_mismatch_valid <= 1'b0;
      first_mismatch_vec   <= '0;
      trojan_flag          <= 1'b0;
    end else if (load_sweep) begin
      idx                  <= '0;
      sof_q                <= stop_on_first;
      mismatch_count       <= '0;
      first_mismatch_valid <= 1'b0;
      first_mismatch_vec   <= '0;
      trojan_flag          <= 1'b0;
    end else begin
      // Compare-cycle update lands even when abort coincides with it.
      if (cmp_fire && mism) begin
        mismatch_count <= sat_inc(mismatch_count);
        trojan_flag    <= 1'b1;
        if (!first_mismatch_valid) begin
          first_mismatch_valid <= 1'b1;
          first_mismatch_vec   <= idx;
        end
      end
      if (advance) idx <= idx + 1'b1;
    end
  end

  assign A    = idx[VEC_W-1 -: DATA_W];
  assign B    = idx[OP_W +: DATA_W];
  assign op   = idx[OP_W-1:0];
  assign busy = (state == SETTLE) || (state == COMPARE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_sweep_controller.sv
// Directed bench for alu_sweep_controller with behavioural golden/suspect ALUs.
module tb_alu_sweep_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, sof = 1'b0;
  logic [3:0]  A, B, clean_r, trojan_r;
  logic [1:0]  op;
  logic        busy, done, fmv, flag;
  logic [10:0] cnt;
  logic [9:0]  fvec, vec;

  logic        start2 = 1'b0, abort2 = 1'b0, sof2 = 1'b0;
  logic [3:0]  A2, B2, clean2, trojan2;
  logic [1:0]  op2;
  logic        busy2, done2, fmv2, flag2;
  logic [10:0] cnt2;
  logic [9:0]  fvec2;

  int mode = 0;
  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  int seq_bad = 0;
  bit seq_en = 0;
  int dc;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
    case (o)
      2'd0:    alu = a + b;
      2'd1:    alu = a - b;
      2'd2:    alu = a & b;
      default: alu = a ^ b;
    endcase
  endfunction

  function automatic logic hit(input logic [9:0] v);
    hit = (mode == 1 && v == 10'h3A7) || (mode == 2 && (v == 10'h010 || v == 10'h200));
  endfunction

  assign vec = {A, B, op};
  always_comb begin
    clean_r  = alu(A, B, op);
    trojan_r = clean_r ^ {3'b000, hit(vec)};
    clean2   = alu(A2, B2, op2);
    trojan2  = clean2;
  end

  alu_sweep_controller #(.DATA_W(4), .OP_W(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_first(sof),
    .A(A), .B(B), .op(op), .clean_result(clean_r), .trojan_result(trojan_r),
    .busy(busy), .done(done), .mismatch_count(cnt), .first_mismatch_valid(fmv),
    .first_mismatch_vec(fvec), .trojan_flag(flag));

  alu_sweep_controller #(.DATA_W(4), .OP_W(2), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .stop_on_first(sof2),
    .A(A2), .B(B2), .op(op2), .clean_result(clean2), .trojan_result(trojan2),
    .busy(busy2), .done(done2), .mismatch_count(cnt2), .first_mismatch_valid(fmv2),
    .first_mismatch_vec(fvec2), .trojan_flag(flag2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    // With SETTLE_CYCLES=1, vector k sits in COMPARE during cycle 2k+2.
    if (seq_en && cyc >= 2 && cyc <= 2048 && (cyc % 2) == 0)
      if (vec !== 10'((cyc / 2) - 1)) seq_bad++;
  endtask

  task automatic do_start;
    @(posedge clk);
    #1;
    start = 1'b1;
    cyc = 0;
    tick;
    start = 1'b0;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick;
  endtask

  task automatic run_done(input int limit, output int d);
    d = -1;
    while (cyc < limit && d < 0) begin
      tick;
      if (done) d = cyc;
    end
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_fmv", fmv, 0);
    chk("rst_fvec", fvec, 0);
    chk("rst_flag", flag, 0);
    chk("rst_vec", vec, 0);
    rst = 1'b0;

    // Identical ALUs, full sweep
    mode = 0; sof = 0; seq_bad = 0; seq_en = 1;
    do_start;
    chk("clean_busy_c1", busy, 1);
    run_done(2200, dc);
    seq_en = 0;
    chk("clean_done_cyc", dc, 2049);
    chk("clean_cnt", cnt, 0);
    chk("clean_flag", flag, 0);
    chk("clean_fmv", fmv, 0);
    chk("clean_seq_errs", seq_bad, 0);
    chk("clean_last_vec", vec, 10'h3FF);
    chk("clean_busy_done", busy, 0);
    abort = 1'b1; tick; abort = 1'b0;
    chk("done_ignores_abort", done, 1);

    // Single difference at 0x3A7
    mode = 1;
    do_start;
    run_done(2200, dc);
    chk("one_done_cyc", dc, 2049);
    chk("one_cnt", cnt, 1);
    chk("one_fvec", fvec, 10'h3A7);
    chk("one_flag", flag, 1);
    chk("one_fmv", fmv, 1);

    // Two differences, stop on first
    mode = 2; sof = 1;
    do_start;
    tick_to(34);
    chk("sof_cmp34_busy", busy, 1);
    chk("sof_cmp34_vec", vec, 10'h010);
    tick;
    chk("sof_done35", done, 1);
    chk("sof_cnt", cnt, 1);
    chk("sof_fvec", fvec, 10'h010);
    repeat (3) tick;
    chk("sof_vec_hold", vec, 10'h010);
    chk("sof_done_hold", done, 1);

    // Same stimulus, no stop; start and abort together in DONE -> start wins
    sof = 0; abort = 1'b1;
    do_start;
    abort = 1'b0;
    chk("startwins_busy", busy, 1);
    chk("startwins_cnt_clr", cnt, 0);
    run_done(2200, dc);
    chk("two_done_cyc", dc, 2049);
    chk("two_cnt", cnt, 2);
    chk("two_fvec", fvec, 10'h010);

    // Reset mid-sweep
    do_start;
    tick_to(500);
    chk("pre_rst_cnt", cnt, 1);
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_fmv", fmv, 0);
    chk("midrst_fvec", fvec, 0);
    chk("midrst_flag", flag, 0);
    chk("midrst_vec", vec, 0);

    // Abort mid-sweep
    do_start;
    tick_to(500);
    abort = 1'b1; tick; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", cnt, 1);
    chk("abort_fmv", fmv, 1);
    chk("abort_fvec", fvec, 10'h010);
    chk("abort_flag", flag, 1);
    repeat (4) tick;
    chk("abort_idle_hold", busy, 0);
    chk("abort_idle_done", done, 0);

    // Restart clears results; a second start at cycle 100 is ignored
    do_start;
    chk("restart_cnt", cnt, 0);
    chk("restart_fmv", fmv, 0);
    chk("restart_flag", flag, 0);
    chk("restart_vec", vec, 0);
    tick_to(100);
    start = 1'b1; tick; start = 1'b0;
    run_done(2200, dc);
    chk("busy_start_done_cyc", dc, 2049);
    chk("busy_start_cnt", cnt, 2);

    // SETTLE_CYCLES = 3 instance
    @(posedge clk); #1;
    start2 = 1'b1; cyc = 0;
    @(posedge clk); #1; cyc++;
    start2 = 1'b0;
    dc = -1;
    while (cyc < 4300 && dc < 0) begin
      @(posedge clk); #1; cyc++;
      if (done2) dc = cyc;
    end
    chk("s3_done_cyc", dc, 4097);
    chk("s3_cnt", cnt2, 0);
    chk("s3_vec", {A2, B2, op2}, 10'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
